trojan_leak_param: RTL and testbench

//  Parametrised trigger-and-leak hardware-trojan benchmark for detection research; next generation of the fixed 48/256 leaker.

---
 rtl/trojan_pkg.sv | 26 ++
 rtl/trojan_leak_sr.sv | 42 ++++
 rtl/trojan_leak_param.sv | 129 ++++++++++++
 tb/tb_trojan_leak_param.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trojan_pkg.sv
// Shared types and sizing helpers for the parametrised trigger-and-leak trojan benchmark.
package trojan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    LEAK    = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int unsigned HIT_W = 8;

  function automatic int unsigned calc_nw(input int unsigned key_w, input int unsigned data_w);
    return key_w / data_w;
  endfunction

  function automatic int unsigned calc_nl(input int unsigned key_w, input int unsigned leak_w);
    return key_w / leak_w;
  endfunction

  // Sized for the longer phase plus one spare bit so the counter never wraps inside a state.
  function automatic int unsigned calc_ctr_w(input int unsigned nw, input int unsigned nl);
    return $clog2((nw > nl) ? nw : nl) + 1;
  endfunction

endpackage

// File: rtl/trojan_leak_sr.sv
// Key shift register: word-indexed parallel load during capture, LSB-first shift-out during leak.
module trojan_leak_sr #(
  parameter int unsigned KEY_W  = 256,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEAK_W = 2,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              shift_i,
  output logic [LEAK_W-1:0] lsb_o
);

  localparam int unsigned NW = KEY_W / DATA_W;

  logic [KEY_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (load_i) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (widx_i == IDX_W'(w)) sr_d[w*DATA_W +: DATA_W] = word_i;
      end
    end else if (shift_i) begin
      sr_d = sr_q >> LEAK_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign lsb_o = sr_q[LEAK_W-1:0];

endmodule

// File: rtl/trojan_leak_param.sv
// Trigger-and-leak trojan: arms on TRIG_HITS pattern matches, captures KEY_W bits, leaks LEAK_W bits/cycle.
// Optional TROJAN_REARM_EN: DONE returns to IDLE so the block can fire repeatedly; otherwise DONE is terminal.
module trojan_leak_param
  import trojan_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       TRIG_W    = 48,
  parameter logic [TRIG_W-1:0] TRIG_VAL  = TRIG_W'(48'h0000_0044_ab93),
  parameter int unsigned       TRIG_HITS = 1,
  parameter int unsigned       KEY_W     = 256,
  parameter int unsigned       LEAK_W    = 2
) (
  input  logic              clk,
  input  logic              rst_all_n,
  input  logic [DATA_W-1:0] data,
  output logic [LEAK_W-1:0] leak_out,
  output logic              leak_vld,
  output logic              busy
);

  localparam int unsigned NW    = calc_nw(KEY_W, DATA_W);
  localparam int unsigned NL    = calc_nl(KEY_W, LEAK_W);
  localparam int unsigned CTR_W = calc_ctr_w(NW, NL);

  if (KEY_W % DATA_W != 0) begin : g_chk_key_data
    $error("KEY_W must be a multiple of DATA_W");
  end
  if (KEY_W % LEAK_W != 0) begin : g_chk_key_leak
    $error("LEAK_W must divide KEY_W");
  end
  if (TRIG_W > DATA_W) begin : g_chk_trig_w
    $error("TRIG_W must not exceed DATA_W");
  end
  if (TRIG_HITS < 1 || TRIG_HITS > 255) begin : g_chk_hits
    $error("TRIG_HITS must be in 1..255");
  end

  state_e             state_q;
  logic [CTR_W-1:0]   ctr_q;
  logic [HIT_W-1:0]   hit_q;
  logic [LEAK_W-1:0]  leak_out_q;
  logic               leak_vld_q;
  logic               busy_q;

  logic               trig_hit_c;
  logic               sr_load_c;
  logic               sr_shift_c;
  logic               sr_clr_c;
  logic [LEAK_W-1:0]  sr_lsb;

  assign trig_hit_c = (data[TRIG_W-1:0] == TRIG_VAL);
  assign sr_load_c  = (state_q == CAPTURE);
  assign sr_shift_c = (state_q == LEAK);
  assign sr_clr_c   = (state_q == DONE);

  trojan_leak_sr #(
    .KEY_W  (KEY_W),
    .DATA_W (DATA_W),
    .LEAK_W (LEAK_W),
    .IDX_W  (CTR_W)
  ) u_sr (
    .clk     (clk),
    .rst_n   (rst_all_n),
    .clr_i   (sr_clr_c),
    .load_i  (sr_load_c),
    .widx_i  (ctr_q),
    .word_i  (data),
    .shift_i (sr_shift_c),
    .lsb_o   (sr_lsb)
  );

  // Control FSM; leak outputs default low every cycle and are only driven while leaking.
  always_ff @(posedge clk or negedge rst_all_n) begin
    if (!rst_all_n) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      hit_q      <= '0;
      leak_out_q <= '0;
      leak_vld_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      leak_out_q <= '0;
      leak_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (trig_hit_c) begin
            hit_q <= hit_q + HIT_W'(1);
            if (hit_q == HIT_W'(TRIG_HITS - 1)) begin
              state_q <= CAPTURE;
              ctr_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (ctr_q == CTR_W'(NW - 1)) begin
            state_q <= LEAK;
            ctr_q   <= '0;
          end else begin
            ctr_q <= ctr_q + CTR_W'(1);
          end
        end
        LEAK: begin
          leak_vld_q <= 1'b1;
          leak_out_q <= sr_lsb;
          if (ctr_q == CTR_W'(NL - 1)) begin
            state_q <= DONE;
            ctr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ctr_q <= ctr_q + CTR_W'(1);
          end
        end
        DONE: begin
`ifdef TROJAN_REARM_EN
          state_q <= IDLE;
          hit_q   <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign leak_out = leak_out_q;
  assign leak_vld = leak_vld_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_trojan_leak_param.sv
// Scoreboard bench for trojan_leak_param: default, TRIG_HITS=3 and narrow-bus instances.
module tb_trojan_leak_param;

  localparam logic [63:0] PAT = 64'h0000_0000_0044_ab93;

  logic        clk = 1'b0;
  logic        rst_all_n;
  logic [63:0] data_a, data_b;
  logic [31:0] data_c;
  logic [1:0]  lo_a, lo_b;
  logic [3:0]  lo_c;
  logic        vld_a, vld_b, vld_c;
  logic        busy_a, busy_b, busy_c;

  logic [3:0]  exp_q[$];
  logic [3:0]  obs_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  trojan_leak_param u_a (
    .clk(clk), .rst_all_n(rst_all_n), .data(data_a),
    .leak_out(lo_a), .leak_vld(vld_a), .busy(busy_a)
  );

  trojan_leak_param #(.TRIG_HITS(3)) u_b (
    .clk(clk), .rst_all_n(rst_all_n), .data(data_b),
    .leak_out(lo_b), .leak_vld(vld_b), .busy(busy_b)
  );

  trojan_leak_param #(
    .DATA_W(32), .TRIG_W(32), .TRIG_VAL(32'h0044_ab93), .KEY_W(128), .LEAK_W(4)
  ) u_c (
    .clk(clk), .rst_all_n(rst_all_n), .data(data_c),
    .leak_out(lo_c), .leak_vld(vld_c), .busy(busy_c)
  );

  task automatic do_reset();
    rst_all_n = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    exp_q.delete(); obs_q.delete();
    repeat (2) @(negedge clk);
    rst_all_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int which, input logic [63:0] w);
    case (which)
      0:       data_a = w;
      1:       data_b = w;
      default: data_c = w[31:0];
    endcase
    @(negedge clk);
  endtask

  // Collects observed leak words; comparisons happen in the calling scenario.
  task automatic drain(input int which, input int cycles, output int n, output int first,
                       output int last, output int stray);
    logic v;
    logic [3:0] o;
    n = 0; first = -1; last = -1; stray = 0;
    for (int k = 0; k < cycles; k++) begin
      case (which)
        0:       begin v = vld_a; o = {2'b00, lo_a}; end
        1:       begin v = vld_b; o = {2'b00, lo_b}; end
        default: begin v = vld_c; o = lo_c; end
      endcase
      if (v) begin
        if (first < 0) first = k;
        last = k;
        n++;
        obs_q.push_back(o);
      end else if (o !== 4'd0) begin
        stray++;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_key64(input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] w2, input logic [63:0] w3);
    logic [255:0] key;
    key = {w3, w2, w1, w0};
    for (int j = 0; j < 128; j++) exp_q.push_back({2'b00, key[2*j +: 2]});
  endtask

  task automatic test_reset();
    rst_all_n = 1'b0;
    data_a = PAT; data_b = PAT; data_c = PAT[31:0];
    #1;
    total++; if (vld_a !== 1'b0)  begin bad++; $display("FAIL rst_vld_a got=%b exp=0", vld_a); end
    total++; if (lo_a !== 2'b00)  begin bad++; $display("FAIL rst_out_a got=%b exp=00", lo_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy_a got=%b exp=0", busy_a); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL rst_busy_b got=%b exp=0", busy_b); end
    total++; if (vld_c !== 1'b0)  begin bad++; $display("FAIL rst_vld_c got=%b exp=0", vld_c); end
    total++; if (lo_c !== 4'h0)   begin bad++; $display("FAIL rst_out_c got=%h exp=0", lo_c); end
    do_reset();
  endtask

  task automatic test_basic();
    int n, first, last, stray;
    logic [63:0] w[4];
    logic [3:0] o, e;
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = 64'h1111 * 64'(i + 1);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy_pre got=%b exp=0", busy_a); end
    send(0, PAT);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL basic_busy_post got=%b exp=1", busy_a); end
    push_key64(w[0], w[1], w[2], w[3]);
    for (int i = 0; i < 4; i++) send(0, w[i]);
    data_a = '0;
    drain(0, 200, n, first, last, stray);
    total++; if (obs_q.size() > 0 && obs_q[0] !== 4'h1) begin
      bad++; $display("FAIL basic_first_out got=%h exp=1", obs_q[0]);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL basic_leak_data got=%h exp=%h", o, e); end
    end
    total++; if (n !== 128) begin bad++; $display("FAIL basic_vld_count got=%0d exp=128", n); end
    total++; if (first !== 1 || last !== 128) begin
      bad++; $display("FAIL basic_vld_window got=%0d..%0d exp=1..128", first, last);
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL basic_idle_out got=%0d exp=0", stray); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy_a); end
  endtask

  task automatic test_hits();
    int n, first, last, stray;
    logic [63:0] w[4];
    logic [3:0] o, e;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL hits_busy_early c=%0d got=%b exp=0", c, busy_b); end
      if (c == 0 || c == 5 || c == 9) send(1, PAT);
      else send(1, {32'($urandom), 16'($urandom), 16'(c)});
    end
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL hits_busy_arm got=%b exp=1", busy_b); end
    for (int i = 0; i < 4; i++) w[i] = {32'($urandom), 32'($urandom)};
    push_key64(w[0], w[1], w[2], w[3]);
    for (int i = 0; i < 4; i++) send(1, w[i]);
    data_b = '0;
    drain(1, 200, n, first, last, stray);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL hits_leak_data got=%h exp=%h", o, e); end
    end
    total++; if (n !== 128 || first !== 1) begin
      bad++; $display("FAIL hits_vld got=%0d@%0d exp=128@1", n, first);
    end
  endtask

  task automatic test_upper();
    int n, first, last, stray;
    logic [63:0] w[4];
    logic [3:0] o, e;
    do_reset();
    send(0, 64'h0000_0000_0044_ab92);
    send(0, 64'h0000_0001_0044_ab93);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL upper_near_miss got=%b exp=0", busy_a); end
    send(0, 64'hFFFF_0000_0044_ab93);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL upper_trigger got=%b exp=1", busy_a); end
    w[0] = {32'($urandom), 32'($urandom)};
    w[1] = PAT;
    w[2] = {32'($urandom), 32'($urandom)};
    w[3] = {32'($urandom), 32'($urandom)};
    push_key64(w[0], w[1], w[2], w[3]);
    for (int i = 0; i < 4; i++) send(0, w[i]);
    data_a = '0;
    drain(0, 200, n, first, last, stray);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL upper_leak_data got=%h exp=%h", o, e); end
    end
    total++; if (n !== 128) begin bad++; $display("FAIL upper_vld_count got=%0d exp=128", n); end
  endtask

  task automatic test_abort();
    int n, first, last, stray, seen;
    bit aborted;
    logic [63:0] w[4];
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = {32'($urandom), 32'($urandom)};
    send(0, PAT);
    push_key64(w[0], w[1], w[2], w[3]);
    for (int i = 0; i < 4; i++) send(0, w[i]);
    data_a = '0;
    seen = 0; aborted = 1'b0;
    for (int k = 0; k < 200 && !aborted; k++) begin
      if (vld_a) begin
        seen++;
        e = exp_q.pop_front(); total++;
        if ({2'b00, lo_a} !== e) begin bad++; $display("FAIL abort_leak_data got=%h exp=%h", lo_a, e); end
      end
      if (seen == 40) begin
        rst_all_n = 1'b0;
        #1;
        aborted = 1'b1;
        total++; if (vld_a !== 1'b0)  begin bad++; $display("FAIL abort_vld got=%b exp=0", vld_a); end
        total++; if (lo_a !== 2'b00)  begin bad++; $display("FAIL abort_out got=%b exp=00", lo_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
      end else begin
        @(negedge clk);
      end
    end
    total++; if (!aborted) begin bad++; $display("FAIL abort_timeout got=%0d exp=40", seen); end
    @(negedge clk);
    rst_all_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    drain(0, 200, n, first, last, stray);
    total++; if (n !== 0) begin bad++; $display("FAIL abort_resume got=%0d exp=0", n); end
    total++; if (stray !== 0) begin bad++; $display("FAIL abort_idle_out got=%0d exp=0", stray); end
  endtask

  task automatic test_rearm();
    int n, first, last, stray, exp_n2;
    logic [63:0] w[4];
    logic [3:0] o, e;
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = {32'($urandom), 32'($urandom)};
    send(0, PAT);
    push_key64(w[0], w[1], w[2], w[3]);
    for (int i = 0; i < 4; i++) send(0, w[i]);
    data_a = '0;
    drain(0, 200, n, first, last, stray);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rearm_first_data got=%h exp=%h", o, e); end
    end
    total++; if (n !== 128) begin bad++; $display("FAIL rearm_first_count got=%0d exp=128", n); end
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 4; i++) w[i] = {32'($urandom), 32'($urandom)};
    send(0, PAT);
`ifdef TROJAN_REARM_EN
    exp_n2 = 128;
    push_key64(w[0], w[1], w[2], w[3]);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rearm_busy got=%b exp=1", busy_a); end
`else
    exp_n2 = 0;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rearm_busy got=%b exp=0", busy_a); end
`endif
    for (int i = 0; i < 4; i++) send(0, w[i]);
    data_a = '0;
    drain(0, 200, n, first, last, stray);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rearm_second_data got=%h exp=%h", o, e); end
    end
    total++; if (n !== exp_n2) begin bad++; $display("FAIL rearm_second_count got=%0d exp=%0d", n, exp_n2); end
    total++; if (stray !== 0) begin bad++; $display("FAIL rearm_idle_out got=%0d exp=0", stray); end
  endtask

  task automatic test_narrow();
    int n, first, last, stray;
    logic [31:0]  w[4];
    logic [127:0] key;
    logic [3:0]   o, e;
    do_reset();
    send(2, PAT);
    total++; if (busy_c !== 1'b1) begin bad++; $display("FAIL narrow_busy got=%b exp=1", busy_c); end
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    key = {w[3], w[2], w[1], w[0]};
    for (int j = 0; j < 32; j++) exp_q.push_back(key[4*j +: 4]);
    for (int i = 0; i < 4; i++) send(2, {32'h0, w[i]});
    data_c = '0;
    drain(2, 100, n, first, last, stray);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL narrow_leak_data got=%h exp=%h", o, e); end
    end
    total++; if (n !== 32) begin bad++; $display("FAIL narrow_vld_count got=%0d exp=32", n); end
    total++; if (first !== 1 || last !== 32) begin
      bad++; $display("FAIL narrow_vld_window got=%0d..%0d exp=1..32", first, last);
    end
  endtask

  initial begin
    rst_all_n = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    test_reset();
    test_basic();
    test_hits();
    test_upper();
    test_abort();
    test_rearm();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
